// File: rtl/clock_seg_display_pkg.sv
// clock_disp_pkg: shared digit indices, segment codes and FSM state type for the clock display.
package clock_disp_pkg;
    localparam int NUM_DIGITS = 6;
    localparam int SEC_U  = 0;
    localparam int SEC_T  = 1;
    localparam int MIN_U  = 2;
    localparam int MIN_T  = 3;
    localparam int HOUR_U = 4;
    localparam int HOUR_T = 5;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    typedef enum logic {IDLE, CONV} state_t;
endpackage

// File: rtl/clock_seg_display_seg7_decode.sv
// seg7_decode: BCD digit (plus blank flag) to active-high {g,f,e,d,c,b,a} pattern.
module seg7_decode
    import clock_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank)
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
    end
endmodule

// File: rtl/clock_seg_display.sv
// clock_seg_display: samples HH:MM:SS, converts to BCD by repeated subtract-by-10, scans a 6-digit 7-seg display.
// Optional macro CLOCK_DISP_LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit.
module clock_seg_display
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV       = 50_000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       load,
    input  logic [5:0] secIn,
    input  logic [5:0] minIn,
    input  logic [4:0] hourIn,
    output logic       busy,
    output logic       rangeErr,
    output logic [5:0] digitSel,
    output logic [6:0] seg
);
    localparam int PW = $clog2(SCAN_DIV);

    state_t         r_state, w_next;
    logic [5:0]     r_sec, r_min;
    logic [4:0]     r_hour;
    logic [2:0]     r_sec_t, r_min_t;
    logic [1:0]     r_hour_t;
    logic           r_err_pend, r_range_err;
    logic [3:0]     r_dig [NUM_DIGITS];
    logic [PW-1:0]  r_pre;
    logic [2:0]     r_idx;
    logic           w_done, w_blank;
    logic [5:0]     w_onehot;
    logic [6:0]     w_seg;

    assign w_done = r_sec < 6'd10 && r_min < 6'd10 && r_hour < 5'd10;

    always_ff @(posedge clk or negedge resetN)
        if (!resetN) r_state <= IDLE;
        else         r_state <= w_next;

    always_comb
        w_next = (r_state == IDLE) ? (load ? CONV : IDLE) : (w_done ? IDLE : CONV);

    always_comb begin
        busy     = r_state == CONV;
        rangeErr = r_range_err;
    end

    // Display registers move only on the commit edge, never mid-conversion.
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            r_sec       <= '0;
            r_min       <= '0;
            r_hour      <= '0;
            r_sec_t     <= '0;
            r_min_t     <= '0;
            r_hour_t    <= '0;
            r_err_pend  <= 1'b0;
            r_range_err <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= '0;
        end else if (r_state == IDLE && load) begin
            r_sec      <= secIn;
            r_min      <= minIn;
            r_hour     <= hourIn;
            r_sec_t    <= '0;
            r_min_t    <= '0;
            r_hour_t   <= '0;
            r_err_pend <= secIn > 6'd59 || minIn > 6'd59 || hourIn > 5'd23;
        end else if (r_state == CONV) begin
            if (w_done) begin
                r_dig[SEC_U]  <= r_sec[3:0];
                r_dig[SEC_T]  <= {1'b0, r_sec_t};
                r_dig[MIN_U]  <= r_min[3:0];
                r_dig[MIN_T]  <= {1'b0, r_min_t};
                r_dig[HOUR_U] <= r_hour[3:0];
                r_dig[HOUR_T] <= {2'b0, r_hour_t};
                r_range_err   <= r_err_pend;
            end else begin
                if (r_sec >= 6'd10) begin
                    r_sec   <= r_sec - 6'd10;
                    r_sec_t <= r_sec_t + 3'd1;
                end
                if (r_min >= 6'd10) begin
                    r_min   <= r_min - 6'd10;
                    r_min_t <= r_min_t + 3'd1;
                end
                if (r_hour >= 5'd10) begin
                    r_hour   <= r_hour - 5'd10;
                    r_hour_t <= r_hour_t + 2'd1;
                end
            end
        end

    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == PW'(SCAN_DIV - 1)) begin
            r_pre <= '0;
            r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end

`ifdef CLOCK_DISP_LEADING_ZERO_BLANK_EN
    assign w_blank = r_idx == 3'(HOUR_T) && r_dig[HOUR_T] == 4'd0;
`else
    assign w_blank = 1'b0;
`endif

    seg7_decode u_dec (
        .i_bcd   (r_dig[r_idx]),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    assign w_onehot = 6'd1 << r_idx;
    assign digitSel = w_onehot ^ {6{SEG_ACTIVE_LOW}};
    assign seg      = w_seg ^ {7{SEG_ACTIVE_LOW}};
endmodule

// File: tb/tb_clock_seg_display.sv
// tb_clock_seg_display: randomized loads checked against an arithmetic model of the BCD digits and scan sequence.
module tb_clock_seg_display;
    localparam int SD = 4;

    logic       clk = 1'b0, resetN = 1'b0, load = 1'b0;
    logic [5:0] secIn = '0, minIn = '0;
    logic [4:0] hourIn = '0;
    logic       busy, rangeErr;
    logic [5:0] digitSel;
    logic [6:0] seg;

    int n_cmp = 0, n_bad = 0;
    int k;
    int exp_dig [6];
    int exp_err;
    int seg_tab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

    clock_seg_display #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .resetN(resetN), .load(load), .secIn(secIn), .minIn(minIn),
        .hourIn(hourIn), .busy(busy), .rangeErr(rangeErr), .digitSel(digitSel), .seg(seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge resetN)
        if (!resetN) k <= 0;
        else         k <= k + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_seg(input int idx);
        int s;
        s = seg_tab[exp_dig[idx]];
`ifdef CLOCK_DISP_LEADING_ZERO_BLANK_EN
        if (idx == 5 && exp_dig[5] == 0) s = 0;
`endif
        return (~s) & 'h7F;
    endfunction

    task automatic check_scan(input int cycles);
        int idx;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            idx = (k / SD) % 6;
            check("digitSel", int'(digitSel), (~(1 << idx)) & 'h3F);
            check("seg", int'(seg), exp_seg(idx));
        end
    endtask

    // Pulse load; optionally try a second (ignored) load on the 2nd busy cycle.
    task automatic do_load(input int s, input int m, input int h, input bit ign);
        int cnt, mx;
        mx = s / 10;
        if (m / 10 > mx) mx = m / 10;
        if (h / 10 > mx) mx = h / 10;
        @(negedge clk);
        load = 1'b1; secIn = 6'(s); minIn = 6'(m); hourIn = 5'(h);
        @(negedge clk);
        load = 1'b0;
        cnt = 0;
        for (int g = 0; g < 30 && busy; g++) begin
            cnt++;
            load = 1'b0;
            if (ign && cnt == 2) begin
                load = 1'b1; secIn = '0; minIn = '0; hourIn = '0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        check("busy_len", cnt, mx + 1);
        exp_dig = '{s % 10, s / 10, m % 10, m / 10, h % 10, h / 10};
        exp_err = (s > 59 || m > 59 || h > 23) ? 1 : 0;
        check("busy_after", int'(busy), 0);
        check("rangeErr", int'(rangeErr), exp_err);
        check_scan(6 * SD);
    endtask

    initial begin
        exp_dig = '{0, 0, 0, 0, 0, 0};
        exp_err = 0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(rangeErr), 0);
        check("rst_sel", int'(digitSel), 'h3E);
        check("rst_seg", int'(seg), 'h40);
        @(negedge clk);
        resetN = 1'b1;
        check_scan(8 * SD);
        do_load(56, 34, 12, 1'b0);
        do_load(59, 59, 23, 1'b1);
        do_load(63, 0, 31, 1'b0);
        do_load(3, 2, 1, 1'b0);
        do_load(0, 0, 5, 1'b0);
        // Reset during the third conversion cycle abandons it.
        @(negedge clk);
        load = 1'b1; secIn = 6'd56; minIn = 6'd34; hourIn = 5'd12;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 resetN = 1'b0;
        #1;
        exp_dig = '{0, 0, 0, 0, 0, 0};
        exp_err = 0;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_sel", int'(digitSel), 'h3E);
        check("mid_rst_seg", int'(seg), 'h40);
        @(negedge clk);
        resetN = 1'b1;
        check_scan(6 * SD);
        do_load(7, 48, 9, 1'b0);
        for (int r = 0; r < 20; r++)
            do_load($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 31), 1'($urandom_range(0, 1)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
